// File: rtl/fmap_write_scheduler_if.sv
// Kernel-side handshake and feature-map write-lane bundle for fmap_write_scheduler.
// FMAP_SCHED_OVERFLOW_DETECT_EN adds the sticky overflow flag to the bundle.
interface fmap_write_scheduler_if #(
  parameter int NumberOfK          = 4,
  parameter int BitSize            = 32,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 4
);
  localparam int TotalPixels = ImageWidth * ImageWidth;
  localparam int KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;
  localparam int AW = (NumberOfK * TotalPixels > 1) ? $clog2(NumberOfK * TotalPixels) : 1;

  logic [NumberOfK-1:0]                       in_valid;
  logic [NumberOfK-1:0][BitSize-1:0]          in_data;
  logic [NumberOfK-1:0]                       in_ready;
  logic [ProcessingElements-1:0]              wr_valid;
  logic [ProcessingElements-1:0][KW-1:0]      wr_kernel;
  logic [ProcessingElements-1:0][AW-1:0]      wr_addr;
  logic [ProcessingElements-1:0][BitSize-1:0] wr_data;
  logic                                       frame_done;
  logic                                       busy;
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
  logic                                       overflow;
`endif

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_valid, wr_kernel, wr_addr, wr_data, frame_done, busy
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_valid, wr_kernel, wr_addr, wr_data, frame_done, busy
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/fmap_write_scheduler.sv
// Round-robin scheduler from per-kernel pixel slots onto the feature-map BRAM write lanes.
// Optional FMAP_SCHED_OVERFLOW_DETECT_EN: sticky flag for kernels pushing past frame end.
module fmap_write_scheduler #(
  parameter int NumberOfK          = 4,
  parameter int BitSize            = 32,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 4
) (
  input  logic                    clk,
  input  logic                    res_n,
  fmap_write_scheduler_if.slave   bus
);
  localparam int TotalPixels = ImageWidth * ImageWidth;
  localparam int KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;
  localparam int AW = (NumberOfK * TotalPixels > 1) ? $clog2(NumberOfK * TotalPixels) : 1;
  localparam int PW = (TotalPixels > 1) ? $clog2(TotalPixels) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                                 state;
  logic [NumberOfK-1:0]                       slot_full;
  logic [NumberOfK-1:0]                       done_mask;
  logic [NumberOfK-1:0][BitSize-1:0]          slot_data;
  logic [PW-1:0]                              pix_cnt [NumberOfK];
  logic [KW-1:0]                              rr_ptr;
  logic [KW-1:0]                              rr_next;
  logic [NumberOfK-1:0]                       cap;
  logic [NumberOfK-1:0]                       gnt;
  logic [NumberOfK-1:0]                       done_set;
  logic [ProcessingElements-1:0]              lane_vld;
  logic [ProcessingElements-1:0][KW-1:0]      lane_k;
  logic [ProcessingElements-1:0][AW-1:0]      lane_addr;
  logic [ProcessingElements-1:0][BitSize-1:0] lane_data;

  // Ready depends only on registers, so kernels never see a path from their own valid.
  assign bus.in_ready   = ~slot_full & ~done_mask & {NumberOfK{state != S_DONE}};
  assign cap            = bus.in_valid & bus.in_ready;
  assign bus.busy       = (state != S_IDLE) || (|slot_full);
  assign bus.frame_done = (state == S_DONE);

  always_comb begin
    int n;
    int idx;
    int last;
    // NOTE: every variable gets a default before the scan so no latch is inferred.
    gnt       = '0;
    done_set  = '0;
    lane_vld  = '0;
    lane_k    = '0;
    lane_addr = '0;
    lane_data = '0;
    n         = 0;
    last      = int'(rr_ptr);
    for (int i = 0; i < NumberOfK; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NumberOfK) idx = idx - NumberOfK;
      if (slot_full[idx] && n < ProcessingElements) begin
        gnt[idx]       = 1'b1;
        done_set[idx]  = (pix_cnt[idx] == PW'(TotalPixels - 1));
        lane_vld[n]    = 1'b1;
        lane_k[n]      = KW'(idx);
        lane_addr[n]   = AW'(idx * TotalPixels) + AW'(pix_cnt[idx]);
        lane_data[n]   = slot_data[idx];
        n              = n + 1;
        last           = idx;
      end
    end
    if (n == 0)                  rr_next = rr_ptr;
    else if (last == NumberOfK - 1) rr_next = '0;
    else                         rr_next = KW'(last + 1);
  end

  // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_IDLE;
      slot_full <= '0;
      done_mask <= '0;
      rr_ptr    <= '0;
      for (int k = 0; k < NumberOfK; k++) pix_cnt[k] <= '0;
    end else begin
      slot_full <= (slot_full & ~gnt) | cap;
      rr_ptr    <= rr_next;
      for (int k = 0; k < NumberOfK; k++) begin
        if (gnt[k]) pix_cnt[k] <= done_set[k] ? '0 : pix_cnt[k] + 1'b1;
      end
      if (state == S_DONE) done_mask <= '0;
      else                 done_mask <= done_mask | done_set;
      case (state)
        S_IDLE:   if (|cap) state <= S_ACTIVE;
        S_ACTIVE: if ((&done_mask) && !(|slot_full)) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // NOTE: slot payload is not reset; slot_full alone qualifies it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumberOfK; k++) begin
      if (cap[k]) slot_data[k] <= bus.in_data[k];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bus.wr_valid  <= '0;
      bus.wr_kernel <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
    end else begin
      bus.wr_valid  <= lane_vld;
      bus.wr_kernel <= lane_k;
      bus.wr_addr   <= lane_addr;
      bus.wr_data   <= lane_data;
    end
  end

`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
  // A finished kernel still presenting data means it ran past the frame end.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                                          bus.overflow <= 1'b0;
    else if (|(bus.in_valid & ~bus.in_ready & done_mask)) bus.overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fmap_write_scheduler.sv
// Self-checking bench for fmap_write_scheduler: vector table, then multi-cycle frame runs
// with a per-kernel scoreboard. Define FMAP_SCHED_OVERFLOW_DETECT_EN to also check overflow.
module tb_fmap_write_scheduler;
  localparam int NK = 4;
  localparam int BS = 32;
  localparam int PE = 2;
  localparam int IW = 4;
  localparam int TP = IW * IW;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  fmap_write_scheduler_if #(.NumberOfK(NK), .BitSize(BS), .ProcessingElements(PE), .ImageWidth(IW)) bus ();

  fmap_write_scheduler #(.NumberOfK(NK), .BitSize(BS), .ProcessingElements(PE), .ImageWidth(IW)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  iv;
    logic [1:0]  ev;
    logic [1:0]  ek0;
    logic [5:0]  ea0;
    logic [31:0] ed0;
    logic [1:0]  ek1;
    logic [5:0]  ea1;
    logic [31:0] ed1;
    logic [3:0]  erdy;
  } vec_t;

  vec_t tbl [12];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sent [NK];
  int wcnt [NK];
  int frame_no;
  int frames_seen;
  int frame_writes;
  int last_wr_cyc;
  int prev_done_cyc;
  logic [63:0] seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sb_clear();
    for (int k = 0; k < NK; k++) begin
      sent[k] = 0;
      wcnt[k] = 0;
    end
    seen          = '0;
    frame_no      = 0;
    frames_seen   = 0;
    frame_writes  = 0;
    last_wr_cyc   = -10;
    prev_done_cyc = -10;
  endtask

  // Called at a negedge with res_n high; leaves reset released at the next negedge.
  task automatic do_reset(input string tag);
    bus.in_valid = '0;
    res_n = 1'b0;
    #1;
    check({tag, "_wr_valid"}, bus.wr_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready, 4'b1111);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
    check({tag, "_overflow"}, bus.overflow, 0);
`endif
    @(negedge clk);
    res_n = 1'b1;
    sb_clear();
  endtask

  task automatic monitor(input int mode);
    for (int l = 0; l < PE; l++) begin
      if (bus.wr_valid[l]) begin
        int k;
        k = int'(bus.wr_kernel[l]);
        check("wr_addr", bus.wr_addr[l], k * TP + wcnt[k]);
        check("wr_data", bus.wr_data[l], (frame_no << 24) | (k << 16) | wcnt[k]);
        check("dup_addr", seen[bus.wr_addr[l]], 0);
        seen[bus.wr_addr[l]] = 1'b1;
        wcnt[k]++;
        frame_writes++;
        if (mode == 2 && last_wr_cyc >= 0) check("k2_spacing", cyc - last_wr_cyc, 2);
        last_wr_cyc = cyc;
      end
    end
    if (bus.wr_valid == 2'b11) check("lane_kernel_distinct", bus.wr_kernel[0] != bus.wr_kernel[1], 1);
    if (bus.frame_done) begin
      check("done_after_last_write", cyc - last_wr_cyc, 1);
      check("frame_writes", frame_writes, NK * TP);
      check("frame_all_addr", seen, {64{1'b1}});
      check("done_in_ready", bus.in_ready, 0);
      check("done_single_pulse", (cyc - prev_done_cyc) > 1, 1);
      for (int k = 0; k < NK; k++) begin
        sent[k] = 0;
        wcnt[k] = 0;
      end
      seen          = '0;
      frame_writes  = 0;
      frame_no++;
      frames_seen++;
      prev_done_cyc = cyc;
    end
  endtask

  // mode 0: all kernels valid, 1: random valid, 2: kernel 2 only.
  task automatic run_traffic(input int mode, input int frames_target, input int budget);
    int start;
    logic [3:0] iv;
    start = frames_seen;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cyc++;
      monitor(mode);
      if (frames_target > 0 && frames_seen - start >= frames_target) break;
      case (mode)
        0:       iv = 4'b1111;
        1:       iv = 4'($urandom_range(0, 15));
        default: iv = 4'b0100;
      endcase
      bus.in_valid = iv;
      for (int k = 0; k < NK; k++) bus.in_data[k] = 32'((frame_no << 24) | (k << 16) | sent[k]);
      for (int k = 0; k < NK; k++) if (iv[k] && bus.in_ready[k]) sent[k]++;
    end
    if (frames_target > 0) begin
      bus.in_valid = '0;
      check("frames_completed", frames_seen - start, frames_target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1111, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b0000};
    tbl[1]  = '{4'b0000, 2'b11, 2'd0, 6'd0,  32'h1,   2'd1, 6'd16, 32'h2,   4'b0011};
    tbl[2]  = '{4'b0000, 2'b11, 2'd2, 6'd32, 32'h3,   2'd3, 6'd48, 32'h4,   4'b1111};
    tbl[3]  = '{4'b0000, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b1111};
    tbl[4]  = '{4'b1001, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b0110};
    tbl[5]  = '{4'b0000, 2'b11, 2'd0, 6'd1,  32'h401, 2'd3, 6'd49, 32'h404, 4'b1111};
    tbl[6]  = '{4'b1010, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b0101};
    tbl[7]  = '{4'b0000, 2'b11, 2'd1, 6'd17, 32'h602, 2'd3, 6'd50, 32'h604, 4'b1111};
    tbl[8]  = '{4'b0111, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b1000};
    tbl[9]  = '{4'b0000, 2'b11, 2'd0, 6'd2,  32'h801, 2'd1, 6'd18, 32'h802, 4'b1011};
    tbl[10] = '{4'b0000, 2'b01, 2'd2, 6'd33, 32'h803, 2'd0, 6'd0,  32'h0,   4'b1111};
    tbl[11] = '{4'b0000, 2'b00, 2'd0, 6'd0,  32'h0,   2'd0, 6'd0,  32'h0,   4'b1111};

    bus.in_valid = '0;
    bus.in_data  = '0;
    res_n = 1'b1;
    @(negedge clk);
    do_reset("init_reset");

    // Vector table: simultaneous requests, lane ordering, round-robin wrap, lane limit.
    for (int r = 0; r < 12; r++) begin
      bus.in_valid = tbl[r].iv;
      for (int k = 0; k < NK; k++) bus.in_data[k] = 32'(r * 256 + k + 1);
      @(negedge clk);
      check($sformatf("row%0d_wr_valid", r), bus.wr_valid, tbl[r].ev);
      check($sformatf("row%0d_in_ready", r), bus.in_ready, tbl[r].erdy);
      check($sformatf("row%0d_busy", r), bus.busy, 1);
      check($sformatf("row%0d_frame_done", r), bus.frame_done, 0);
      if (tbl[r].ev[0]) begin
        check($sformatf("row%0d_l0_kernel", r), bus.wr_kernel[0], tbl[r].ek0);
        check($sformatf("row%0d_l0_addr", r), bus.wr_addr[0], tbl[r].ea0);
        check($sformatf("row%0d_l0_data", r), bus.wr_data[0], tbl[r].ed0);
      end
      if (tbl[r].ev[1]) begin
        check($sformatf("row%0d_l1_kernel", r), bus.wr_kernel[1], tbl[r].ek1);
        check($sformatf("row%0d_l1_addr", r), bus.wr_addr[1], tbl[r].ea1);
        check($sformatf("row%0d_l1_data", r), bus.wr_data[1], tbl[r].ed1);
      end
    end

    // Reset while slots are full and writes are in flight.
    bus.in_valid = 4'b1111;
    @(negedge clk);
    bus.in_valid = '0;
    @(negedge clk);
    check("midrun_wr_valid_before", bus.wr_valid, 2'b11);
    check("midrun_busy_before", bus.busy, 1);
    do_reset("midrun_reset");

    // Single kernel streaming to the end of its frame share, then stalled.
    run_traffic(2, 0, 50);
    check("k2_write_count", wcnt[2], TP);
    check("k2_no_frame_done", frames_seen, 0);
    check("k2_stalled_ready", bus.in_ready, 4'b1011);
    check("k2_busy", bus.busy, 1);
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
    check("overflow_set", bus.overflow, 1);
`endif

    // Remaining kernels finish the same frame while kernel 2 keeps pushing.
    run_traffic(0, 1, 200);
`ifdef FMAP_SCHED_OVERFLOW_DETECT_EN
    check("overflow_sticky_over_done", bus.overflow, 1);
`endif
    @(negedge clk);
    check("after_done1_in_ready", bus.in_ready, 4'b1111);
    check("after_done1_busy", bus.busy, 0);
    check("after_done1_frame_done", bus.frame_done, 0);
    do_reset("post_overflow_reset");

    // Full frame with every kernel valid from a clean start.
    run_traffic(0, 1, 300);
    @(negedge clk);
    check("after_done2_in_ready", bus.in_ready, 4'b1111);
    check("after_done2_busy", bus.busy, 0);

    // Three frames of random request patterns.
    run_traffic(1, 3, 3000);
    @(negedge clk);
    check("after_rand_in_ready", bus.in_ready, 4'b1111);
    check("after_rand_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
